// File: rtl/sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding and
// default parameter values.
package sequencer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_STACK_DEPTH = 4;
  localparam int unsigned DEF_RESET_ADDR  = 0;

endpackage : sequencer_pkg

// File: rtl/seq_return_stack.sv
// LIFO of return addresses for the program sequencer.
// Ports:
//   clk, rst         clock, async active-high reset (clears depth only)
//   push_i, pop_i    push data_i / pop top entry (ignored when full / empty)
//   data_i           address to push
//   top_o            current top-of-stack entry (undefined when empty)
//   depth_o          registered entry count, 0..STACK_DEPTH
//   empty_o, full_o  registered flags for depth 0 / STACK_DEPTH
module seq_return_stack
  import sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_i,
  input  logic                               pop_i,
  input  logic [ADDR_W-1:0]                  data_i,
  output logic [ADDR_W-1:0]                  top_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
  output logic                               empty_o,
  output logic                               full_o
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              empty_q, full_q;
  logic              do_push, do_pop;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q && !push_i;

  // Write slot is the current depth; top entry sits one below it.
  assign wr_ptr = PTR_W'(depth_q);
  assign rd_ptr = PTR_W'(depth_q - CNT_W'(1));

  // Next depth count
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + CNT_W'(1);
    end else if (do_pop) begin
      depth_d = depth_q - CNT_W'(1);
    end
  end

  // Depth and flags; flags track depth_d so they stay registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      depth_q <= depth_d;
      empty_q <= (depth_d == '0);
      full_q  <= (depth_d == CNT_W'(STACK_DEPTH));
    end
  end

  // Storage needs no reset; only the depth count defines validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign top_o   = mem_q[rd_ptr];
  assign depth_o = depth_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule : seq_return_stack

// File: rtl/program_sequencer.sv
// Instruction-fetch address sequencer with increment, jump, call/return
// via a hardware return stack, halt/resume and an absorbing fault state.
// Ports:
//   clk, rst                     clock, async active-high reset
//   step                         advance enable while running
//   load, call, ret, target      jump / call / return requests and target
//   halt, resume                 enter / leave the halted state
//   address_out                  registered fetch address
//   stack_empty, stack_full      return-stack occupancy flags
//   fault, halted                state indicators
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned RESET_ADDR  = DEF_RESET_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] address_out,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              fault,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, halted_q;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic [CNT_W-1:0]  stk_depth;
  logic              stk_empty, stk_full;

  seq_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ADDR_W'(addr_q + ADDR_W'(1))),
    .top_o   (stk_top),
    .depth_o (stk_depth),
    .empty_o (stack_empty),
    .full_o  (stack_full)
  );

  assign stk_empty = (stk_depth == '0);
  assign stk_full  = (stk_depth == CNT_W'(STACK_DEPTH));

  // Next state / address; one action per step, halt > ret > call > load > inc
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      RUN: begin
        if (step) begin
          if (halt) begin
            state_d = HALTED;
          end else if (ret) begin
            if (stk_empty) begin
              state_d = FAULT;
            end else begin
              pop    = 1'b1;
              addr_d = stk_top;
            end
          end else if (call) begin
            if (stk_full) begin
              state_d = FAULT;
            end else begin
              push   = 1'b1;
              addr_d = target;
            end
          end else if (load) begin
            addr_d = target;
          end else begin
            addr_d = ADDR_W'(addr_q + ADDR_W'(1));
          end
        end
      end
      HALTED: begin
        if (resume && !halt) begin
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // State, address and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      addr_q   <= ADDR_W'(RESET_ADDR);
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fault_q  <= (state_d == FAULT);
      halted_q <= (state_d == HALTED);
    end
  end

  assign address_out = addr_q;
  assign fault       = fault_q;
  assign halted      = halted_q;

endmodule : program_sequencer
